sha256_hash_sequencer: RTL
==========================

# sha256_hash_sequencer

Control FSM that runs a SHA-256 hash of an 80-byte (640-bit) block header through an external single-block compression core. It pads the header into two 512-bit message blocks and issues them in order, chaining the intermediate digest between them. When double hashing is enabled, it then pads and issues the first digest as a third block. It sits between the header source and the compression core and owns all padding, chaining and pass sequencing.

## Interface
- `DOUBLE_HASH`, default 1: 1 = SHA-256d (three blocks); 0 = single SHA-256 (two blocks).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `header` in 640: header, bit 639 = first message bit; captured on accepted `start`.
- `iv` in 256: initial hash values H0..H7, H0 in [255:224]; captured on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` through DONE.
- `done` out 1: one-cycle pulse, final digest valid.
- `hash` out 256: final digest; holds until the next accepted `start`.
- `blk_valid` out 1: block request to the core.
- `blk_ready` in 1: core accepts the block when `blk_valid && blk_ready`.
- `blk_data` out 512: padded message block.
- `blk_chain` out 256: chaining value for this block.
- `blk_idx` out 2: 0/1 = header blocks, 2 = digest block.
- `dig_valid` in 1: core result strobe.
- `dig` in 256: core result, already added to `blk_chain` (updated H).

## Operation
- States: IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, D_REQ, D_WAIT, DONE.
- IDLE:
  - `start` captures `header` and `iv`.
  - Next state is B0_REQ.
  - `start` in any other state is ignored.
- B0_REQ:
  - `blk_data = header[639:128]`, `blk_chain = iv`, `blk_idx = 0`.
  - On handshake, go to B0_WAIT.
- B0_WAIT:
  - On `dig_valid`, register `dig` as `mid`.
  - Go to B1_REQ.
- B1_REQ:
  - `blk_data = {header[127:0], 1'b1, 319'b0, 64'd640}`, `blk_chain = mid`, `blk_idx = 1`.
  - On handshake, go to B1_WAIT.
- B1_WAIT:
  - On `dig_valid`, register `dig` as `h1`.
  - If `DOUBLE_HASH`, go to D_REQ; otherwise load `hash = dig` and go to DONE.
- D_REQ:
  - `blk_data = {h1, 1'b1, 191'b0, 64'd256}`, `blk_chain = captured iv`, `blk_idx = 2`.
  - On handshake, go to D_WAIT.
- D_WAIT: on `dig_valid`, load `hash = dig` and go to DONE.
- DONE: `done = 1` for one cycle, then IDLE.
- Handshake rules:
  - `blk_valid` is high in the *_REQ states only.
  - `blk_data`, `blk_chain` and `blk_idx` are stable while `blk_valid` is high and not yet accepted.
  - `blk_valid` drops the cycle after acceptance.
- `dig_valid` outside the *_WAIT states is ignored. It does not corrupt `mid`, `h1` or `hash`.
- `blk_ready` outside the *_REQ states is ignored.
- The length fields are fixed constants in bits: 640 for the header pass, 256 for the digest pass.
- Reset:
  - State goes to IDLE.
  - `busy = 0`, `done = 0`, `blk_valid = 0`, `blk_idx = 0`.
  - `hash`, `blk_data`, `blk_chain`, `mid` and `h1` clear to 0.
  - Reset mid-operation abandons the job; a `dig_valid` arriving later is ignored.

## Timing
- Accepted `start` at cycle N gives `busy = 1` and `blk_valid = 1` at N+1.
- With `blk_ready` tied high and a core latency of L cycles, the REQ→WAIT→REQ turnaround is 1 cycle of REQ plus L cycles.
- The next REQ state is entered the cycle after `dig_valid`.
- `done` and the `hash` update occur the cycle after the final `dig_valid`.
- IDLE is re-entered the cycle after `done`, so the next `start` is accepted one cycle after `done`.
- If `start` coincides with `rst`, reset wins.
- `dig_valid` may arrive in the cycle immediately after the handshake (L = 1).
- All outputs are registered.

## Structure
- Shared package `sha256_pkg` holds:
  - `SHA256_IV` (the standard H0..H7 constant);
  - block/digest width constants (512, 256);
  - the length constants `HDR_LEN_BITS = 640` and `DIG_LEN_BITS = 256`;
  - the state enum.
- One sub-module is natural: `sha256_pad`. It is combinational and produces the three padded blocks from `header` and `h1`; the FSM muxes among them by `blk_idx`.
- The compression core is external and not part of this block.

## Test plan
- Genesis header with `iv = SHA256_IV`, a reference core model and `DOUBLE_HASH = 1` → three blocks with `blk_idx` 0, 1, 2; `hash = 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000`; `done` is a single pulse.
- `header = 640'h1`, stub core returning `dig = 256'hA5..A5` → B1 `blk_data = {128'h1, 1'b1, 319'b0, 64'h280}` and `blk_chain = A5..A5`; D `blk_data = {256'hA5..A5, 1'b1, 191'b0, 64'h100}` and `blk_chain = iv`.
- `DOUBLE_HASH = 0`, stub `dig` = 0x11..11 then 0x22..22 → exactly two handshakes; `hash = 0x22..22`; `done` one cycle after the second `dig_valid`.
- `blk_ready` held low for 5 cycles in B1_REQ → `blk_valid` stays high and `blk_data` is unchanged for all 5 cycles; a single handshake only.
- Spurious `dig_valid` in IDLE and in B0_REQ, plus a second `start` during B0_WAIT → no state change and `hash` unchanged; the job completes normally.
- `rst` asserted in D_WAIT, then `dig_valid` arrives → IDLE, all outputs 0, no `done`; a fresh `start` then completes correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 header hash sequencer.
package sha256_pkg;

  localparam int BLK_W = 512;
  localparam int DIG_W = 256;
  localparam int HDR_W = 640;

  // Message lengths in bits, appended as the final 64 bits of each last block.
  localparam logic [63:0] HDR_LEN_BITS = 64'd640;
  localparam logic [63:0] DIG_LEN_BITS = 64'd256;

  // Standard SHA-256 initial hash values H0..H7, H0 in the top word.
  localparam logic [DIG_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // blk_idx encodings seen by the compression core.
  localparam logic [1:0] IDX_HDR0 = 2'd0;
  localparam logic [1:0] IDX_HDR1 = 2'd1;
  localparam logic [1:0] IDX_DIG  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    B0_REQ,
    B0_WAIT,
    B1_REQ,
    B1_WAIT,
    D_REQ,
    D_WAIT,
    DONE
  } seq_state_t;

  // True in the states that present a block to the core.
  function automatic logic is_req(input seq_state_t s);
    return (s == B0_REQ) || (s == B1_REQ) || (s == D_REQ);
  endfunction

endpackage

// File: rtl/sha256_pad.sv
// Combinational SHA-256 padding for the two header blocks and the digest block.
module sha256_pad
  import sha256_pkg::*;
(
  input  logic [HDR_W-1:0] header,
  input  logic [DIG_W-1:0] h1,
  output logic [BLK_W-1:0] blk0,
  output logic [BLK_W-1:0] blk1,
  output logic [BLK_W-1:0] blk2
);

  // First 64 header bytes fill block 0 exactly.
  assign blk0 = header[HDR_W-1:128];

  // Remaining 16 header bytes, the 0x80 marker, zero fill and the 640-bit length.
  assign blk1 = {header[127:0], 1'b1, 319'd0, HDR_LEN_BITS};

  // 32-byte first digest re-hashed as a single padded block.
  assign blk2 = {h1, 1'b1, 191'd0, DIG_LEN_BITS};

endmodule

// File: rtl/sha256_hash_sequencer.sv
// Sequences a padded 80-byte header (and optionally its digest) through an
// external single-block SHA-256 compression core, chaining digests between blocks.
module sha256_hash_sequencer
  import sha256_pkg::*;
#(
  parameter bit DOUBLE_HASH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [HDR_W-1:0] header,
  input  logic [DIG_W-1:0] iv,
  output logic             busy,
  output logic             done,
  output logic [DIG_W-1:0] hash,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic [DIG_W-1:0] blk_chain,
  output logic [1:0]       blk_idx,
  input  logic             dig_valid,
  input  logic [DIG_W-1:0] dig
);

  seq_state_t state, state_nxt;

  logic [HDR_W-1:0] hdr_q, hdr_nxt;
  logic [DIG_W-1:0] iv_q, iv_nxt;
  logic [DIG_W-1:0] mid, mid_nxt;
  logic [DIG_W-1:0] h1, h1_nxt;
  logic [DIG_W-1:0] hash_nxt;
  logic [BLK_W-1:0] blk_data_nxt;
  logic [DIG_W-1:0] blk_chain_nxt;
  logic [1:0]       blk_idx_nxt;
  logic [BLK_W-1:0] pad_blk0, pad_blk1, pad_blk2;
  logic             hs;

  assign hs = blk_valid && blk_ready;

  // Padding is built from the next-cycle header/h1 so registered block outputs
  // are ready in the same cycle the REQ state is entered.
  sha256_pad u_pad (
    .header (hdr_nxt),
    .h1     (h1_nxt),
    .blk0   (pad_blk0),
    .blk1   (pad_blk1),
    .blk2   (pad_blk2)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and capture of header, iv and intermediate digests.
  always_comb begin
    state_nxt = state;
    hdr_nxt   = hdr_q;
    iv_nxt    = iv_q;
    mid_nxt   = mid;
    h1_nxt    = h1;
    hash_nxt  = hash;
    case (state)
      IDLE: begin
        if (start) begin
          hdr_nxt   = header;
          iv_nxt    = iv;
          state_nxt = B0_REQ;
        end
      end
      B0_REQ:  if (hs) state_nxt = B0_WAIT;
      B0_WAIT: begin
        if (dig_valid) begin
          mid_nxt   = dig;
          state_nxt = B1_REQ;
        end
      end
      B1_REQ:  if (hs) state_nxt = B1_WAIT;
      B1_WAIT: begin
        if (dig_valid) begin
          h1_nxt = dig;
          if (DOUBLE_HASH) begin
            state_nxt = D_REQ;
          end else begin
            hash_nxt  = dig;
            state_nxt = DONE;
          end
        end
      end
      D_REQ:   if (hs) state_nxt = D_WAIT;
      D_WAIT: begin
        if (dig_valid) begin
          hash_nxt  = dig;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Block fields follow the REQ state being entered or held; they hold otherwise,
  // which keeps them stable for the whole request.
  always_comb begin
    blk_idx_nxt   = blk_idx;
    blk_chain_nxt = blk_chain;
    blk_data_nxt  = blk_data;
    case (state_nxt)
      B0_REQ: begin
        blk_idx_nxt   = IDX_HDR0;
        blk_chain_nxt = iv_nxt;
      end
      B1_REQ: begin
        blk_idx_nxt   = IDX_HDR1;
        blk_chain_nxt = mid_nxt;
      end
      D_REQ: begin
        blk_idx_nxt   = IDX_DIG;
        blk_chain_nxt = iv_nxt;
      end
      default: ;
    endcase
    if (is_req(state_nxt)) begin
      case (blk_idx_nxt)
        IDX_HDR0: blk_data_nxt = pad_blk0;
        IDX_HDR1: blk_data_nxt = pad_blk1;
        default:  blk_data_nxt = pad_blk2;
      endcase
    end
  end

  // Registered outputs and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      blk_valid <= 1'b0;
      blk_idx   <= 2'd0;
      blk_data  <= '0;
      blk_chain <= '0;
      hash      <= '0;
      mid       <= '0;
      h1        <= '0;
      hdr_q     <= '0;
      iv_q      <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      blk_valid <= is_req(state_nxt);
      blk_idx   <= blk_idx_nxt;
      blk_data  <= blk_data_nxt;
      blk_chain <= blk_chain_nxt;
      hash      <= hash_nxt;
      mid       <= mid_nxt;
      h1        <= h1_nxt;
      hdr_q     <= hdr_nxt;
      iv_q      <= iv_nxt;
    end
  end

endmodule
